// File: rtl/pingpong_pixel_buf.sv
// Two-bank pixel buffer: the writer fills one bank while the reader drains the other.
// Define PPB_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module pingpong_pixel_buf #(
  parameter int DEPTH = 10000,
  parameter int CH    = 3,
  parameter int CW    = 8,
  parameter int AW    = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CH*CW-1:0] wr_data,
  output logic             wr_ready,
  output logic             wr_bank,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [CH*CW-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_done,
  output logic [1:0]       bank_full,
  output logic             underrun
`ifdef PPB_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  localparam int DW = CH * CW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LIM  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  logic [DW-1:0] mem [2][DEPTH];
  logic          rd_bank;

  logic       wr_in;
  logic       rd_in;
  logic       wr_acc;
  logic       wr_last;
  logic       rd_ok;
  logic       rd_miss;
  logic       rel;
  logic [1:0] full_nxt;

  assign wr_ready = ~bank_full[wr_bank];
  assign wr_in    = {1'b0, wr_addr} < LIM;
  assign rd_in    = {1'b0, rd_addr} < LIM;
  assign wr_acc   = ~reset & wr_en & wr_ready & wr_in;
  assign wr_last  = wr_acc & ({1'b0, wr_addr} == LAST);
  assign rd_ok    = rd_en & bank_full[rd_bank] & rd_in;
  assign rd_miss  = rd_en & ~bank_full[rd_bank];
  assign rel      = rd_done & bank_full[rd_bank];

  // A final write and a release never target the same bank:
  // the write needs its bank empty, the release needs its bank full.
  always_comb begin
    full_nxt = bank_full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rel)     full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_bank][wr_addr[IW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      bank_full <= full_nxt;
      rd_valid  <= rd_ok;
      if (rd_ok)   rd_data  <= mem[rd_bank][rd_addr[IW-1:0]];
      if (rd_miss) underrun <= 1'b1;
      if (wr_last) wr_bank  <= ~wr_bank;
      if (rel)     rd_bank  <= ~rd_bank;
    end
  end

`ifdef PPB_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (rd_miss && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule
